// File: rtl/irq_controller.sv
// irq_controller: memory-mapped interrupt controller for the single-cycle CPU.
// Peripheral edge events are latched in PEND. Each source has a mask bit, and
// there is one global enable. The lowest eligible source index wins. The CPU
// kernel-mode bit acts as the take acknowledge. Each interrupt passes through
// ASSERT, then SERVICE, then an EOI write. Read data is 0 when the block is not
// selected, so it can be ORed onto the shared read bus.
// Build option: define IRQ_LEVEL_EN to make PEND follow the source levels
// directly. In that build there is no edge detector, PEND writes are ignored
// and PEND is not cleared on service entry.
`timescale 1ns/1ps
module irq_controller #(
  parameter int          NSRC      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0030
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            kernel,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            irq,
  output logic [3:0]      irq_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Register word offsets inside the block
  localparam logic [2:0] REG_PEND  = 3'd0;
  localparam logic [2:0] REG_MASK  = 3'd1;
  localparam logic [2:0] REG_CTRL  = 3'd2;
  localparam logic [2:0] REG_CAUSE = 3'd3;
  localparam logic [2:0] REG_EOI   = 3'd4;

  state_t          state_q, state_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic            gie_q, gie_d;
  logic [3:0]      irq_id_q, irq_id_d;
  logic            irq_q;

  logic [29:0]     word_off;
  logic            hit;
  logic [2:0]      reg_sel;
  logic            wr_pend, wr_mask, wr_ctrl, wr_eoi;
  logic [NSRC-1:0] eligible;
  logic            mask_at_id;
  logic            svc_clr;
  logic            unused_bits;

  // Lowest set index of a request vector; 0 when none are set
  function automatic logic [3:0] lowest_idx(input logic [NSRC-1:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // One-hot decode of a source index, limited to the implemented sources
  function automatic logic [NSRC-1:0] idx_onehot(input logic [3:0] idx);
    logic [NSRC-1:0] r;
    r = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (idx == 4'(i)) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Word-granular decode: byte lanes addr[1:0] are ignored. The subtraction
  // wraps, so addresses below the base fall outside the 5-word window.
  assign word_off = addr[31:2] - BASE_ADDR[31:2];
  assign hit      = (word_off < 30'd5);
  assign reg_sel  = word_off[2:0];
  assign wr_pend  = wr & hit & (reg_sel == REG_PEND);
  assign wr_mask  = wr & hit & (reg_sel == REG_MASK);
  assign wr_ctrl  = wr & hit & (reg_sel == REG_CTRL);
  assign wr_eoi   = wr & hit & (reg_sel == REG_EOI);

  assign eligible   = pend_q & mask_q;
  assign mask_at_id = |(mask_q & idx_onehot(irq_id_q));

  // Combinational bus read; returns zero unless this block is selected
  always_comb begin
    rdata = 32'h0;
    if (rd && hit) begin
      case (reg_sel)
        REG_PEND:  rdata[NSRC-1:0] = pend_q;
        REG_MASK:  rdata[NSRC-1:0] = mask_q;
        REG_CTRL:  rdata[0]        = gie_q;
        REG_CAUSE: begin
          rdata[31]  = (state_q == ST_SERVICE);
          rdata[3:0] = irq_id_q;
        end
        default:   rdata = 32'h0;
      endcase
    end
  end

  // Software-visible configuration registers
  always_comb begin
    mask_d = mask_q;
    gie_d  = gie_q;
    if (wr_mask) mask_d = wdata[NSRC-1:0];
    if (wr_ctrl) gie_d  = wdata[0];
  end

  // Interrupt sequencing: winner selection, take acknowledge, abort and EOI
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    svc_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gie_q && (|eligible) && !kernel) begin
          state_d  = ST_ASSERT;
          irq_id_d = lowest_idx(eligible);
        end
      end
      ST_ASSERT: begin
        // The latched winner is held; a higher-priority arrival waits
        if (kernel) begin
          state_d = ST_SERVICE;
          svc_clr = 1'b1;
        end else if (!gie_q || !mask_at_id) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (wr_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef IRQ_LEVEL_EN
  // Pending bits mirror the source levels; software writes have no effect
  always_comb begin
    pend_d = src;
  end

  assign unused_bits = ^{addr[1:0], wdata[31:NSRC], svc_clr, wr_pend};
`else
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] entry_clr;

  assign rise      = src & ~src_q;
  assign w1c       = wr_pend ? wdata[NSRC-1:0] : '0;
  assign entry_clr = svc_clr ? idx_onehot(irq_id_q) : '0;

  // Edge latch: a new edge beats a software clear, and the clear on
  // service entry beats a new edge on the bit being taken
  always_comb begin
    pend_d = ((pend_q & ~w1c) | rise) & ~entry_clr;
  end

  // Previous-cycle source levels for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) src_q <= '0;
    else       src_q <= src;
  end

  assign unused_bits = ^{addr[1:0], wdata[31:NSRC]};
`endif

  // State and register update; reset clears everything including service
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      mask_q   <= '0;
      gie_q    <= 1'b0;
      irq_id_q <= 4'd0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      gie_q    <= gie_d;
      irq_id_q <= irq_id_d;
      irq_q    <= (state_d == ST_ASSERT);
    end
  end

  assign irq    = irq_q;
  assign irq_id = irq_id_q;

endmodule
